// File: rtl/mem_port_arbiter.sv
// Shares one asynchronous SRAM between the fetch (read-only) and data (read/write)
// requesters; data has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned READ_WAIT    = 1,
    parameter int unsigned WE_CYCLES    = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_wr_en,
    output logic          ram_ce_n,
    output logic          ram_oe_n,
    output logic          ram_we_n,
    output logic          busy
);

    localparam int unsigned CW = 3;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [SW-1:0] starve_cnt;
    logic          owner_dm;
    logic          dm_win, if_win;
    logic          capture;
    logic          ce_n_d, oe_n_d, we_n_d, wr_en_d, if_ack_d, dm_ack_d, busy_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic, including the grant decision taken in IDLE
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dm_win     = 1'b0;
        if_win     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                dm_win   = dm_req && !(if_req && (starve_cnt == SW'(STARVE_LIMIT)));
                if_win   = !dm_win && if_req;
                if (dm_win) begin
                    state_next = dm_we ? WR_SETUP : RD;
                end else if (if_win) begin
                    state_next = RD;
                end
            end
            RD: begin
                if (cnt == CW'(READ_WAIT)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WR_SETUP: begin
                state_next = WR_PULSE;
                cnt_next   = '0;
            end
            WR_PULSE: begin
                if (cnt == CW'(WE_CYCLES - 1)) begin
                    state_next = WR_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WR_HOLD: state_next = DONE;
            DONE:    state_next = IDLE;
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the pins come straight from flops
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        wr_en_d  = 1'b0;
        if_ack_d = 1'b0;
        dm_ack_d = 1'b0;
        busy_d   = (state_next != IDLE);
        case (state_next)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d  = 1'b0;
                wr_en_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d  = 1'b0;
                wr_en_d = 1'b1;
                we_n_d  = 1'b0;
            end
            DONE: begin
                if_ack_d = !owner_dm;
                dm_ack_d = owner_dm;
            end
            default: ;
        endcase
    end

    assign capture = (state == RD) && (state_next == DONE);

    // Registered pins, latched operands, read data and starvation tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_ce_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_wr_en  <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            busy       <= 1'b0;
            owner_dm   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            ram_ce_n  <= ce_n_d;
            ram_oe_n  <= oe_n_d;
            ram_we_n  <= we_n_d;
            ram_wr_en <= wr_en_d;
            if_ack    <= if_ack_d;
            dm_ack    <= dm_ack_d;
            busy      <= busy_d;
            if (dm_win) begin
                owner_dm  <= 1'b1;
                ram_addr  <= dm_addr;
                ram_wdata <= dm_wdata;
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else if (if_win) begin
                owner_dm   <= 1'b0;
                ram_addr   <= if_addr;
                starve_cnt <= '0;
            end
            if (capture) begin
                if (owner_dm) begin
                    dm_rdata <= ram_rdata;
                end else begin
                    if_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule
